// File: rtl/fp_pkg.sv
// Shared fixed-point helpers: saturation limits, saturation classification and
// round-half-up, shared by the MAC pipeline and the fixed-point multiplier.
package fp_pkg;

  localparam int unsigned MAX_W = 64;

  typedef logic signed [MAX_W-1:0] wide_t;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_POS  = 2'd1,
    SAT_NEG  = 2'd2
  } sat_e;

  // Most negative value of a w-bit signed number, sign-extended to MAX_W.
  function automatic wide_t sat_min(input int unsigned w);
    return {MAX_W{1'b1}} << (w - 1);
  endfunction

  function automatic wide_t sat_max(input int unsigned w);
    return ~sat_min(w);
  endfunction

  function automatic sat_e sat_class(input wide_t x, input int unsigned w);
    if (x > sat_max(w)) begin
      return SAT_POS;
    end else if (x < sat_min(w)) begin
      return SAT_NEG;
    end
    return SAT_NONE;
  endfunction

  function automatic wide_t round_half_up(input wide_t p, input int unsigned f);
    return (p + (wide_t'(1) <<< (f - 1))) >>> f;
  endfunction

endpackage

// File: rtl/fp_sat_round.sv
// Combinational S2 datapath: round the full product, optionally accumulate
// with a clamped guard-bit accumulator, then saturate to the output width.
module fp_sat_round
  import fp_pkg::*;
#(
  parameter int unsigned W_len     = 16,
  parameter int unsigned W_fract   = 14,
  parameter int unsigned ACC_GUARD = 4
) (
  input  logic signed [2*W_len-1:0]         full_prod,
  input  logic signed [W_len+ACC_GUARD-1:0] acc,
  input  logic                              acc_en,
  input  logic                              acc_clr,
  output logic signed [W_len+ACC_GUARD-1:0] acc_next,
  output logic signed [W_len-1:0]           result,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int unsigned AW = W_len + ACC_GUARD;
  localparam wide_t ACC_MAX = sat_max(AW);
  localparam wide_t ACC_MIN = sat_min(AW);
  localparam wide_t OUT_MAX = sat_max(W_len);
  localparam wide_t OUT_MIN = sat_min(W_len);

  wide_t rounded;
  wide_t sum;
  wide_t acc_clamped;
  wide_t pre_sat;
  sat_e  acc_cls;
  sat_e  out_cls;

  always_comb begin
    rounded = round_half_up(wide_t'(full_prod), W_fract);
    sum     = (acc_clr ? '0 : wide_t'(acc)) + rounded;

    acc_cls = sat_class(sum, AW);
    case (acc_cls)
      SAT_POS: acc_clamped = ACC_MAX;
      SAT_NEG: acc_clamped = ACC_MIN;
      default: acc_clamped = sum;
    endcase
    acc_next = acc_clamped[AW-1:0];

    pre_sat   = acc_en ? acc_clamped : rounded;
    out_cls   = sat_class(pre_sat, W_len);
    result    = pre_sat[W_len-1:0];
    overflow  = 1'b0;
    underflow = 1'b0;
    case (out_cls)
      SAT_POS: begin
        result   = OUT_MAX[W_len-1:0];
        overflow = 1'b1;
      end
      SAT_NEG: begin
        result    = OUT_MIN[W_len-1:0];
        underflow = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fp_mac_pipe.sv
// Two-stage fixed-point multiply/accumulate pipeline with valid/ready flow
// control: S1 holds the full product, S2 holds the rounded saturated result.
module fp_mac_pipe
  import fp_pkg::*;
#(
  parameter int unsigned W_len     = 16,
  parameter int unsigned W_fract   = 14,
  parameter int unsigned ACC_GUARD = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W_len-1:0] a,
  input  logic signed [W_len-1:0] b,
  input  logic                    acc_en,
  input  logic                    acc_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [W_len-1:0] product,
  output logic                    overflow,
  output logic                    underflow
);

  typedef struct packed {
    logic                      valid;
    logic                      acc_en;
    logic                      acc_clr;
    logic signed [2*W_len-1:0] prod;
  } s1_t;

  s1_t                              s1;
  logic                             advance;
  logic signed [W_len+ACC_GUARD-1:0] acc;
  logic signed [W_len+ACC_GUARD-1:0] acc_next;
  logic signed [W_len-1:0]          res;
  logic                             res_ovf;
  logic                             res_unf;

  // Both stages move together; a full S2 that is not drained freezes the pipe.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
    end else if (advance) begin
      s1.valid <= in_valid;
      if (in_valid) begin
        s1.prod    <= (2*W_len)'(a) * (2*W_len)'(b);
        s1.acc_en  <= acc_en;
        s1.acc_clr <= acc_clr;
      end
    end
  end

  fp_sat_round #(
    .W_len    (W_len),
    .W_fract  (W_fract),
    .ACC_GUARD(ACC_GUARD)
  ) u_sat_round (
    .full_prod(s1.prod),
    .acc      (acc),
    .acc_en   (s1.acc_en),
    .acc_clr  (s1.acc_clr),
    .acc_next (acc_next),
    .result   (res),
    .overflow (res_ovf),
    .underflow(res_unf)
  );

  // Accumulator only commits when a real beat crosses into S2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      product   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      acc       <= '0;
    end else if (advance) begin
      out_valid <= s1.valid;
      if (s1.valid) begin
        product   <= res;
        overflow  <= res_ovf;
        underflow <= res_unf;
        if (s1.acc_en) begin
          acc <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_mac_pipe.sv
// Self-checking bench for fp_mac_pipe against an integer-arithmetic reference.
module tb_fp_mac_pipe;

  localparam int W = 16;
  localparam int F = 14;
  localparam int G = 4;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [W-1:0] a;
  logic signed [W-1:0] b;
  logic               acc_en;
  logic               acc_clr;
  logic               out_valid;
  logic               out_ready;
  logic signed [W-1:0] product;
  logic               overflow;
  logic               underflow;

  fp_mac_pipe #(.W_len(W), .W_fract(F), .ACC_GUARD(G)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .acc_en   (acc_en),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] val;
    int          cyc;
    string       name;
  } rec_t;

  rec_t   exp_q[$];
  rec_t   got_q[$];
  longint macc;
  int     cyc;
  int     total;
  int     bad;

  // Reference: exact product, round half up, guarded accumulator, saturate.
  function automatic logic [17:0] model_beat(input logic [15:0] ia, input logic [15:0] ib,
                                             input bit en, input bit clr);
    longint p, r, x, lim;
    p = longint'($signed(ia)) * longint'($signed(ib));
    r = (p + (longint'(1) <<< (F - 1))) >>> F;
    x = r;
    if (en) begin
      lim = longint'(1) <<< (W + G - 1);
      x = (clr ? 0 : macc) + r;
      if (x > lim - 1) x = lim - 1;
      if (x < -lim) x = -lim;
      macc = x;
    end
    if (x > 32767) return {16'h7FFF, 2'b10};
    if (x < -32768) return {16'h8000, 2'b01};
    return {x[15:0], 2'b00};
  endfunction

  task automatic cycle(input bit v, input logic [15:0] ia, input logic [15:0] ib,
                       input bit en, input bit clr, input bit ordy, input string nm);
    @(negedge clk);
    in_valid  = v;
    a         = ia;
    b         = ib;
    acc_en    = en;
    acc_clr   = clr;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) got_q.push_back('{{product, overflow, underflow}, cyc, ""});
    if (in_valid && in_ready) exp_q.push_back('{model_beat(ia, ib, en, clr), cyc, nm});
    cyc++;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && got_q.size() < exp_q.size(); i++) cycle(0, 0, 0, 0, 0, 1, "idle");
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (product !== 16'h0000) begin bad++; $display("FAIL reset_product got=%h exp=0000", product); end
    total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {overflow, underflow}); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    macc = 0;
  endtask

  task automatic test_directed;
    logic [15:0] va[5];
    logic [15:0] vb[5];
    logic [17:0] lit[5];
    va  = '{16'h2000, 16'h7777, 16'h7079, 16'h0001, 16'hFFFF};
    vb  = '{16'h9000, 16'h8887, 16'h7078, 16'h2000, 16'h2000};
    lit = '{{16'hC800, 2'b00}, {16'h8000, 2'b01}, {16'h7FFF, 2'b10}, {16'h0001, 2'b00}, {16'h0000, 2'b00}};
    for (int i = 0; i < 5; i++) cycle(1, va[i], vb[i], 0, 0, 1, $sformatf("directed%0d", i));
    drain(10);
    total++;
    if (got_q.size() != 5) begin bad++; $display("FAIL directed_count got=%0d exp=5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].val !== lit[i]) begin
        bad++; $display("FAIL %s {product,ovf,unf} got=%h exp=%h", exp_q[i].name, got_q[i].val, lit[i]);
      end
      total++;
      if (got_q[i].val !== exp_q[i].val) begin
        bad++; $display("FAIL %s_model got=%h exp=%h", exp_q[i].name, got_q[i].val, exp_q[i].val);
      end
      total++;
      if (got_q[i].cyc - exp_q[i].cyc != 2) begin
        bad++; $display("FAIL %s_latency got=%0d exp=2", exp_q[i].name, got_q[i].cyc - exp_q[i].cyc);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_accum;
    bit          en[7];
    bit          clr[7];
    logic [17:0] lit[7];
    en  = '{1, 1, 1, 1, 0, 1, 1};
    clr = '{1, 0, 0, 0, 1, 0, 1};
    lit = '{{16'h2000, 2'b00}, {16'h4000, 2'b00}, {16'h6000, 2'b00}, {16'h7FFF, 2'b10},
            {16'h2000, 2'b00}, {16'h7FFF, 2'b10}, {16'h2000, 2'b00}};
    for (int i = 0; i < 7; i++) cycle(1, 16'h2000, 16'h4000, en[i], clr[i], 1, $sformatf("accum%0d", i));
    drain(10);
    total++;
    if (got_q.size() != 7) begin bad++; $display("FAIL accum_count got=%0d exp=7", got_q.size()); end
    for (int i = 0; i < 7 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].val !== lit[i]) begin
        bad++; $display("FAIL %s {product,ovf,unf} got=%h exp=%h", exp_q[i].name, got_q[i].val, lit[i]);
      end
      total++;
      if (got_q[i].cyc - exp_q[i].cyc != 2) begin
        bad++; $display("FAIL %s_latency got=%0d exp=2", exp_q[i].name, got_q[i].cyc - exp_q[i].cyc);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_stall;
    logic [17:0] lit[3];
    lit = '{{16'h2000, 2'b00}, {16'h5000, 2'b00}, {16'h4000, 2'b00}};
    cycle(1, 16'h2000, 16'h4000, 1, 1, 1, "stall_a");
    cycle(1, 16'h3000, 16'h4000, 1, 0, 0, "stall_b");
    for (int i = 0; i < 2; i++) begin
      cycle(1, 16'h1000, 16'hC000, 1, 0, 0, "stall_c");
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready%0d got=%b exp=0", i, in_ready); end
      total++; if (product !== 16'sh2000) begin bad++; $display("FAIL stall_hold%0d got=%h exp=2000", i, product); end
    end
    cycle(1, 16'h1000, 16'hC000, 1, 0, 1, "stall_c");
    drain(10);
    total++;
    if (got_q.size() != 3 || exp_q.size() != 3) begin
      bad++; $display("FAIL stall_count got=%0d accepted=%0d exp=3", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < 3 && i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i].val !== lit[i] || exp_q[i].val !== lit[i]) begin
        bad++; $display("FAIL %s got=%h model=%h exp=%h", exp_q[i].name, got_q[i].val, exp_q[i].val, lit[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random;
    logic [15:0] ra, rb;
    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
      cycle($urandom_range(0, 9) < 7, ra, rb, $urandom_range(0, 9) < 6,
            $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 7, "random");
    end
    drain(50);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL random_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i].val !== exp_q[i].val) begin
        bad++; $display("FAIL random_beat%0d {product,ovf,unf} got=%h exp=%h", i, got_q[i].val, exp_q[i].val);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_midstream;
    cycle(1, 16'h7079, 16'h7078, 1, 1, 0, "pre_a");
    cycle(1, 16'h2000, 16'h4000, 1, 0, 0, "pre_b");
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if ({out_valid, overflow} !== 2'b11) begin bad++; $display("FAIL midrst_pre got=%b exp=11", {out_valid, overflow}); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL midrst_flags got=%b exp=00", {overflow, underflow}); end
    exp_q.delete(); got_q.delete();
    macc = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    cycle(1, 16'h2000, 16'h4000, 1, 0, 1, "post_rst");
    drain(10);
    total++;
    if (got_q.size() != 1) begin
      bad++; $display("FAIL post_rst_count got=%0d exp=1", got_q.size());
    end else if (got_q[0].val !== {16'h2000, 2'b00} || exp_q[0].val !== {16'h2000, 2'b00}) begin
      bad++; $display("FAIL post_rst_acc got=%h model=%h exp=%h", got_q[0].val, exp_q[0].val, {16'h2000, 2'b00});
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; macc = 0;
    in_valid = 0; a = '0; b = '0; acc_en = 0; acc_clr = 0; out_ready = 1;
    test_reset;
    test_directed;
    test_accum;
    test_stall;
    test_random;
    test_reset_midstream;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/fp_mac_pipe.md
FP_MAC_PIPE -- requirements
Module: fp_mac_pipe

Interface
REQ-001 Parameter W_len, default 16, total signed operand/result width in bits.
REQ-002 Parameter W_fract, default 14, fractional bits (Q(W_len-W_fract).W_fract); 1 <= W_fract < W_len.
REQ-003 Parameter ACC_GUARD, default 4, extra integer bits in the internal accumulator.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 a, b  input  W_len each  signed operands.
REQ-009 acc_en  input  1  sampled with the beat; 1 = accumulate, 0 = plain multiply.
REQ-010 acc_clr  input  1  sampled with the beat; 1 = accumulator treated as zero before adding this beat.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 product  output  W_len  signed saturated result.
REQ-014 overflow  output  1  result saturated to positive maximum; qualified by out_valid.
REQ-015 underflow  output  1  result saturated to negative minimum; qualified by out_valid.

Function
REQ-016 Two-stage pipeline: S1 registers full 2*W_len product and sideband bits; S2 registers rounded/accumulated/saturated result.
REQ-017 advance = !out_valid || out_ready; in_ready = advance; when advance=0 both stages hold, with no beat lost or duplicated.
REQ-018 Beat accepted when in_valid && in_ready; with out_ready held at 1, product appears exactly 2 cycles after acceptance, one result per cycle.
REQ-019 Rounding: round half up -- add 2^(W_fract-1) to the full product, then arithmetic shift right by W_fract.
REQ-020 acc_en=0: result = sat(rounded); accumulator unchanged.
REQ-021 acc_en=1: acc_next = (acc_clr ? 0 : acc) + rounded, clamped to the W_len+ACC_GUARD signed range; acc <= acc_next; result = sat(acc_next).
REQ-022 sat(x): x > 2^(W_len-1)-1 -> 2^(W_len-1)-1 with overflow=1; x < -2^(W_len-1) -> -2^(W_len-1) with underflow=1; otherwise x with both flags 0.
REQ-023 The accumulator updates only when the beat moves from S1 to S2, never during a stall.
REQ-024 acc_clr with acc_en=0 has no effect.
REQ-025 Bubbles (S1 empty) move through S2 without touching the accumulator.

Reset
REQ-026 On reset: in-flight beats discarded, both stage valids=0, accumulator=0, out_valid=0, product=0, overflow=0, underflow=0.
REQ-027 in_ready=1 in the first cycle after reset deasserts.
REQ-028 Reset asserted mid-stream takes effect asynchronously, regardless of stall state.

Structure
REQ-029 Shared package fp_pkg holds the saturation limit constants and the round/saturate function signatures, shared with fp_mult.
REQ-030 Sub-module fp_sat_round (combinational: round, shift, saturate, flags) is instantiated in S2.

Verification (Q2.14 defaults; out_ready=1 unless stated)
REQ-031 a=0x2000, b=0x9000, acc_en=0 -> product=0xC800, flags 0, 2 cycles after acceptance.
REQ-032 a=0x7777, b=0x8887 -> product=0x8000, underflow=1; a=0x7079, b=0x7078 -> product=0x7FFF, overflow=1.
REQ-033 a=0x0001, b=0x2000 -> product=0x0001 (half rounds up); a=0xFFFF, b=0x2000 -> product=0x0000.
REQ-034 Four beats a=0x2000, b=0x4000, acc_en=1, acc_clr=1 on the first beat only -> products 0x2000, 0x4000, 0x6000, 0x7FFF, with overflow=1 on the fourth beat only; a fifth beat with acc_clr=1 -> 0x2000.
REQ-035 out_ready held at 0 for 3 cycles with 3 beats offered -> in_ready=0 once S2 is full; on release, results emerge in order, none lost or duplicated, and the accumulator sum matches the reference model.
REQ-036 reset pulsed while both stages are valid -> out_valid=0 and flags 0 immediately; the next acc_en beat without acc_clr starts from an accumulator of 0.
